pipe_mem_stage_fpu: RTL and testbench
=====================================

Name: pipe_mem_stage_fpu

Overview:
- MEM stage of the integer/FP pipeline. Sits between the E/M pipeline register and the M/W register (pipe_intr_m2w_reg_fpu).
- Runs a req/ack handshake with a variable-latency data memory. Stalls upstream stages while an access is outstanding.
- Aligns and extends load data. Forwards writeback controls, including the FP-register write flag, to the M/W register.
- Inserts bubbles into M/W while stalled.

Parameters:
- AW, 32, data-memory byte-address width. dmem_addr is word-aligned.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- mwreg  in  1  integer regfile write
- mm2reg  in  1  load (result from memory)
- mwmem  in  1  store
- mwfpr  in  1  FP regfile write
- msize  in  2  00 byte, 01 half, 10 word (11 treated as word)
- munsigned  in  1  zero-extend sub-word load
- malu  in  32  effective address / ALU result
- mb  in  32  store data
- mrn  in  5  destination register
- dmem_req  out  1  access request
- dmem_we  out  1  write strobe
- dmem_addr  out  AW  {addr[AW-1:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid same cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  hold PC, F/D, D/E, E/M
- m_misalign  out  1  misaligned-access exception pulse
- owreg, om2reg, owfpr  out  1 each  controls to M/W
- omo  out  32  aligned load data
- oalu  out  32  malu pass-through
- orn  out  5  mrn pass-through

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE; latched addr/be/wdata/we and load buffer cleared.
  - dmem_req=0, mem_stall=0, m_misalign=0, omo=0.
  - Other outputs follow their inputs as below (all 0 when inputs are 0).
- memop = mm2reg | mwmem.
- misalign = (msize=01 & malu[0]) | (msize>=10 & malu[1:0]!=0).
- Non-memop or misaligned: single cycle, no stall.
  - oalu=malu, orn=mrn, omo=0.
  - Controls pass through, except misaligned memops: m_misalign=1 and owreg/om2reg/owfpr forced 0 that cycle.
- States are IDLE, WAIT and DONE (2-bit register).
- IDLE with an aligned memop:
  - dmem_req=1 driven combinationally from inputs; request fields latched.
  - If dmem_ack is seen the same cycle: capture the aligned load into the buffer and go to DONE.
  - Otherwise go to WAIT.
- WAIT: dmem_req=1 driven from latched fields. On dmem_ack, capture and go to DONE.
- DONE:
  - dmem_req=0, mem_stall=0.
  - omo=buffer; controls pass through.
  - Always go to IDLE.
- mem_stall = memop & ~misalign & (state != DONE).
- While mem_stall=1, owreg, om2reg and owfpr are forced 0 so M/W captures a bubble.
- Latency is 2 cycles with a zero-wait memory and N+2 cycles with N wait cycles.
- Inputs are stable from IDLE through DONE, because upstream is held by mem_stall.
- Store byte enables:
  - byte: be=1<<addr[1:0], wdata={4{mb[7:0]}}.
  - half: be=addr[1]?1100:0011, wdata={2{mb[15:0]}}.
  - word: be=1111, wdata=mb.
- Loads drive dmem_we=0 and the same be.
- Loads select the lane by addr[1:0]. Sub-word results are sign-extended unless munsigned=1.
- An FP load (mwfpr & mm2reg) is always word-sized.
- dmem_ack while dmem_req=0 is ignored. The memory must not hold ack across a dropped request.
- rst during WAIT abandons the transaction and drops dmem_req at once. A late ack is ignored.

Decomposition:
- Package pipe_mem_pkg holds:
  - msize encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state encoding (ST_IDLE, ST_WAIT, ST_DONE).
- One combinational sub-module, dmem_lane_align:
  - store be/wdata generation;
  - load lane select and extension.

Test Plan:
- Non-memop, mwreg=1, malu=0x1234, mrn=7 -> same cycle: owreg=1, oalu=0x1234, orn=7, mem_stall=0, dmem_req=0.
- lw from 0x100, ack same cycle, rdata=0xDEADBEEF -> stall 1 cycle; next cycle DONE with omo=0xDEADBEEF, om2reg=1, stall=0.
- lb from 0x103, rdata=0x80FF0000, ack after 3 wait cycles -> 4 bubble cycles (owreg=0), then omo=0xFFFFFF80. With munsigned=1 -> omo=0x00000080.
- sh of mb=0x0000ABCD to 0x202 -> dmem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1.
- FP load (mwfpr=1, mm2reg=1) from 0x1F6 -> no request, m_misalign=1, owfpr=0, no stall.
- rst pulsed during WAIT, then ack arrives -> dmem_req=0 immediately, state=IDLE, ack ignored, all outputs 0.

Source files
------------

// File: rtl/pipe_mem_stage_fpu_pkg.sv
// Shared encodings for the MEM stage: access sizes and handshake FSM states.
package pipe_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_mem_stage_fpu_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface pipe_mem_stage_fpu_if #(
  parameter int AW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          ack;
  logic [31:0]   rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/pipe_mem_stage_fpu_dmem_lane_align.sv
// Byte-lane steering: store enables/replicated data and load lane select with extension.
module dmem_lane_align
  import pipe_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        unsgn,
  input  logic [1:0]  off,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);
  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    be       = 4'b1111;
    wdata    = sdata;
    ldata    = rdata;
    byte_sel = lane[off];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{sdata[7:0]}};
        ldata = {{24{byte_sel[7] & ~unsgn}}, byte_sel};
      end
      SZ_HALF: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata[15:0]}};
        ldata = {{16{half_sel[15] & ~unsgn}}, half_sel};
      end
      default: ;  // word and the reserved encoding 11 both behave as word
    endcase
  end
endmodule

// File: rtl/pipe_mem_stage_fpu.sv
// MEM pipeline stage: variable-latency data-memory handshake, stall/bubble control and load alignment.
module pipe_mem_stage_fpu
  import pipe_mem_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mwreg,
  input  logic                 mm2reg,
  input  logic                 mwmem,
  input  logic                 mwfpr,
  input  logic [1:0]           msize,
  input  logic                 munsigned,
  input  logic [31:0]          malu,
  input  logic [31:0]          mb,
  input  logic [4:0]           mrn,
  pipe_mem_stage_fpu_if.master dmem,
  output logic                 mem_stall,
  output logic                 m_misalign,
  output logic                 owreg,
  output logic                 om2reg,
  output logic                 owfpr,
  output logic [31:0]          omo,
  output logic [31:0]          oalu,
  output logic [4:0]           orn
);
  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg;
  logic [3:0]    be_reg;
  logic [31:0]   wdata_reg;
  logic          we_reg;
  logic [31:0]   buf_reg;

  logic [1:0]    eff_size;
  logic          memop, misalign, access, capture;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata, al_ldata;

  // FP loads fill a whole FP register, so they are word accesses regardless of msize
  assign eff_size = (mwfpr & mm2reg) ? SZ_WORD : msize;
  assign memop    = mm2reg | mwmem;
  assign misalign = ((eff_size == SZ_HALF) & malu[0]) | (eff_size[1] & (|malu[1:0]));
  assign access   = memop & ~misalign;

  dmem_lane_align u_align (
    .size  (eff_size),
    .unsgn (munsigned),
    .off   (malu[1:0]),
    .sdata (mb),
    .rdata (dmem.rdata),
    .be    (al_be),
    .wdata (al_wdata),
    .ldata (al_ldata)
  );

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    dmem.req   = 1'b0;
    dmem.we    = mwmem;
    dmem.addr  = {malu[AW-1:2], 2'b00};
    dmem.be    = al_be;
    dmem.wdata = al_wdata;
    case (state_reg)
      ST_IDLE: begin
        if (access) begin
          dmem.req = 1'b1;
          if (dmem.ack) begin
            capture    = 1'b1;
            state_next = ST_DONE;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        dmem.req   = 1'b1;
        dmem.we    = we_reg;
        dmem.addr  = addr_reg;
        dmem.be    = be_reg;
        dmem.wdata = wdata_reg;
        if (dmem.ack) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // reset must drop the request immediately, not only after the state register clears
    if (rst) begin
      dmem.req = 1'b0;
      capture  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      be_reg    <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      buf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && access) begin
        addr_reg  <= {malu[AW-1:2], 2'b00};
        be_reg    <= al_be;
        wdata_reg <= al_wdata;
        we_reg    <= mwmem;
      end
      if (capture) buf_reg <= al_ldata;
    end
  end

  assign mem_stall  = access & (state_reg != ST_DONE) & ~rst;
  assign m_misalign = memop & misalign & ~rst;
  // stalled or faulting cycles hand a bubble to M/W
  assign owreg  = mwreg  & ~mem_stall & ~m_misalign;
  assign om2reg = mm2reg & ~mem_stall & ~m_misalign;
  assign owfpr  = mwfpr  & ~mem_stall & ~m_misalign;
  assign omo    = (state_reg == ST_DONE) ? buf_reg : 32'd0;
  assign oalu   = malu;
  assign orn    = mrn;
endmodule

// File: tb/tb_pipe_mem_stage_fpu.sv
// Directed and randomized checks of the MEM stage against an arithmetic reference model.
module tb_pipe_mem_stage_fpu;
  logic        clk = 1'b0;
  logic        rst;
  logic        mwreg, mm2reg, mwmem, mwfpr, munsigned;
  logic [1:0]  msize;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        mem_stall, m_misalign, owreg, om2reg, owfpr;
  logic [31:0] omo, oalu;
  logic [4:0]  orn;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipe_mem_stage_fpu_if #(.AW(32)) dmem ();

  pipe_mem_stage_fpu #(.AW(32)) dut (
    .clk(clk), .rst(rst),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .mwfpr(mwfpr),
    .msize(msize), .munsigned(munsigned), .malu(malu), .mb(mb), .mrn(mrn),
    .dmem(dmem.master),
    .mem_stall(mem_stall), .m_misalign(m_misalign),
    .owreg(owreg), .om2reg(om2reg), .owfpr(owfpr),
    .omo(omo), .oalu(oalu), .orn(orn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input int sz, input logic uns, input int off, input logic [31:0] w);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (w >> (8 * off)) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_be(input int sz, input int off);
    if (sz == 0) return 32'(1 << off);
    if (sz == 1) return 32'(3 << off);
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] b);
    if (sz == 0) return (b % 256) * 32'h01010101;
    if (sz == 1) return (b % 65536) * 32'h00010001;
    return b;
  endfunction

  // One instruction through the stage; entered and left just after a rising edge.
  task automatic run_op(input logic wreg, input logic m2r, input logic wmem, input logic fpr,
                        input logic [1:0] sz, input logic uns, input logic [31:0] alu,
                        input logic [31:0] b, input logic [4:0] rn, input int waits,
                        input logic [31:0] rd);
    int  esz, off;
    logic mem, mis;
    mwreg = wreg; mm2reg = m2r; mwmem = wmem; mwfpr = fpr;
    msize = sz; munsigned = uns; malu = alu; mb = b; mrn = rn;
    dmem.ack = 1'b0; dmem.rdata = $urandom;
    esz = (fpr && m2r) ? 2 : ((sz == 0) ? 0 : (sz == 1) ? 1 : 2);
    off = int'(alu % 4);
    mem = m2r || wmem;
    mis = (esz == 1) ? (off % 2 != 0) : (esz == 2) ? (off != 0) : 1'b0;
    $display("op m2r=%0d wmem=%0d fpr=%0d sz=%0d uns=%0d addr=%08h mb=%08h waits=%0d rdata=%08h",
             m2r, wmem, fpr, sz, uns, alu, b, waits, rd);
    if (!mem || mis) begin
      @(negedge clk);
      chk("req_single", 32'(dmem.req), 32'd0);
      chk("stall_single", 32'(mem_stall), 32'd0);
      chk("misalign", 32'(m_misalign), 32'(mem && mis));
      chk("owreg_single", 32'(owreg), 32'(wreg && !(mem && mis)));
      chk("om2reg_single", 32'(om2reg), 32'(m2r && !(mem && mis)));
      chk("owfpr_single", 32'(owfpr), 32'(fpr && !(mem && mis)));
      chk("oalu", oalu, alu);
      chk("orn", 32'(orn), 32'(rn));
      chk("omo_single", omo, 32'd0);
      @(posedge clk); #1;
    end else begin
      for (int c = 0; c <= waits; c++) begin
        dmem.ack   = (c == waits);
        dmem.rdata = (c == waits) ? rd : $urandom;
        @(negedge clk);
        chk("req_busy", 32'(dmem.req), 32'd1);
        chk("stall_busy", 32'(mem_stall), 32'd1);
        chk("bubble", 32'({owreg, om2reg, owfpr}), 32'd0);
        chk("addr", dmem.addr, alu - 32'(off));
        chk("be", 32'(dmem.be), ref_be(esz, off));
        chk("we", 32'(dmem.we), 32'(wmem));
        if (wmem) chk("wdata", dmem.wdata, ref_wdata(esz, b));
        @(posedge clk); #1;
      end
      dmem.ack = 1'b0; dmem.rdata = $urandom;
      @(negedge clk);
      chk("req_done", 32'(dmem.req), 32'd0);
      chk("stall_done", 32'(mem_stall), 32'd0);
      chk("owreg_done", 32'(owreg), 32'(wreg));
      chk("om2reg_done", 32'(om2reg), 32'(m2r));
      chk("owfpr_done", 32'(owfpr), 32'(fpr));
      if (m2r) chk("omo", omo, ref_load(esz, uns, off, rd));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // reset with an aligned load presented: no request, controls follow inputs
    rst = 1'b1; dmem.ack = 1'b0; dmem.rdata = 32'd0;
    mwreg = 1; mm2reg = 1; mwmem = 0; mwfpr = 0; msize = 2'b10; munsigned = 0;
    malu = 32'h40; mb = 32'd0; mrn = 5'd3;
    @(negedge clk);
    chk("rst_req", 32'(dmem.req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_omo", omo, 32'd0);
    chk("rst_owreg", 32'(owreg), 32'd1);
    chk("rst_om2reg", 32'(om2reg), 32'd1);
    malu = 32'h41;
    #1 chk("rst_misalign", 32'(m_misalign), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // test-plan items
    run_op(1, 0, 0, 0, 2'b10, 0, 32'h1234, 32'h0, 5'd7, 0, 32'h0);
    run_op(1, 1, 0, 0, 2'b10, 0, 32'h100, 32'h0, 5'd4, 0, 32'hDEADBEEF);
    run_op(1, 1, 0, 0, 2'b00, 0, 32'h103, 32'h0, 5'd5, 3, 32'h80FF0000);
    run_op(1, 1, 0, 0, 2'b00, 1, 32'h103, 32'h0, 5'd5, 3, 32'h80FF0000);
    run_op(0, 0, 1, 0, 2'b01, 0, 32'h202, 32'h0000ABCD, 5'd0, 0, 32'h0);
    run_op(0, 1, 0, 1, 2'b00, 0, 32'h1F6, 32'h0, 5'd9, 0, 32'h0);
    run_op(1, 1, 0, 0, 2'b11, 0, 32'h2C8, 32'h0, 5'd2, 1, 32'h89ABCDEF);

    // reset while waiting: request drops at once and a late ack is ignored
    mwreg = 1; mm2reg = 1; mwmem = 0; mwfpr = 0; msize = 2'b10; munsigned = 0;
    malu = 32'h300; mb = 32'd0; mrn = 5'd6; dmem.ack = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 32'(dmem.req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_wait_req", 32'(dmem.req), 32'd0);
    chk("rst_wait_stall", 32'(mem_stall), 32'd0);
    mwreg = 0; mm2reg = 0; malu = 32'd0; mrn = 5'd0; msize = 2'b00;
    dmem.ack = 1'b1; dmem.rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("late_ack_req", 32'(dmem.req), 32'd0);
    chk("late_ack_outs", {omo[31:6], owreg, om2reg, owfpr, mem_stall, m_misalign, 1'b0} | omo | oalu | 32'(orn), 32'd0);
    @(posedge clk); #1;
    dmem.ack = 1'b0;
    @(negedge clk);
    chk("late_ack_omo", omo, 32'd0);
    @(posedge clk); #1;

    // randomized mix of ALU ops, loads and stores
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic fp;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      fp   = (kind == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      a    = $urandom_range(0, 4095);
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      run_op((kind != 2) && !fp, kind == 1, kind == 2, fp, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
